// File: rtl/silent_stepper_mc.sv
// silent_stepper_mc: time-multiplexed per-channel slew limiter for duty (saturating) and phase (circular).
// Optional macro SILENT_CONVERGED_EN adds CONVERGED, set when the finished sweep reached every target.
module silent_stepper_mc #(
  parameter int TRANS_NUM = 249,
  parameter int W         = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   ENABLE,
  input  logic                   UPDATE,
  input  logic [W-1:0]           STEP_DUTY,
  input  logic [W-1:0]           STEP_PHASE,
  input  logic [W*TRANS_NUM-1:0] DUTY,
  input  logic [W*TRANS_NUM-1:0] PHASE,
  output logic [W*TRANS_NUM-1:0] DUTYS,
  output logic [W*TRANS_NUM-1:0] PHASES,
  output logic                   BUSY,
  output logic                   OUT_VALID
`ifdef SILENT_CONVERGED_EN
  ,
  output logic                   CONVERGED
`endif
);

  localparam int CH_W = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1;
  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(TRANS_NUM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Unsigned move toward target, never wrapping past either end.
  function automatic logic [W-1:0] slew_duty(input logic [W-1:0] cur, input logic [W-1:0] tgt,
                                             input logic [W-1:0] step);
    logic signed [W:0] d;
    logic [W:0]        mag;
    logic [W-1:0]      res;
    d   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag = d[W] ? $unsigned(-d) : $unsigned(d);
    if (mag <= {1'b0, step}) begin
      res = tgt;
    end else if (d[W]) begin
      res = cur - step;
    end else begin
      res = cur + step;
    end
    return res;
  endfunction

  // Circular move along the shorter arc; an exact half turn goes forward.
  function automatic logic [W-1:0] slew_phase(input logic [W-1:0] cur, input logic [W-1:0] tgt,
                                              input logic [W-1:0] step);
    logic [W-1:0] d;
    logic [W-1:0] mag;
    logic [W-1:0] res;
    d   = tgt - cur;
    mag = d[W-1] ? (-d) : d;
    if (mag <= step) begin
      res = tgt;
    end else if (d[W-1] && (d != {1'b1, {(W-1){1'b0}}})) begin
      res = cur - step;
    end else begin
      res = cur + step;
    end
    return res;
  endfunction

  state_t                 state_r;
  logic [CH_W-1:0]        idx_r;
  logic                   pending_r;
  logic                   enable_r;
  logic [W-1:0]           step_duty_r;
  logic [W-1:0]           step_phase_r;
  logic [W*TRANS_NUM-1:0] dutys_r;
  logic [W*TRANS_NUM-1:0] phases_r;
  logic                   busy_r;
  logic                   out_valid_r;

  logic [W-1:0] tgt_duty_s;
  logic [W-1:0] tgt_phase_s;
  logic [W-1:0] new_duty_s;
  logic [W-1:0] new_phase_s;

  // Shared datapath: next values for the channel selected by idx_r.
  always_comb begin
    tgt_duty_s  = DUTY[idx_r*W +: W];
    tgt_phase_s = PHASE[idx_r*W +: W];
    if (enable_r) begin
      new_duty_s  = slew_duty(dutys_r[idx_r*W +: W], tgt_duty_s, step_duty_r);
      new_phase_s = slew_phase(phases_r[idx_r*W +: W], tgt_phase_s, step_phase_r);
    end else begin
      new_duty_s  = tgt_duty_s;
      new_phase_s = tgt_phase_s;
    end
  end

`ifdef SILENT_CONVERGED_EN
  logic ok_s;
  logic conv_acc_r;
  logic converged_r;
  assign ok_s      = (new_duty_s == tgt_duty_s) && (new_phase_s == tgt_phase_s);
  assign CONVERGED = converged_r;
`endif

  // Sweep sequencer, channel writes and registered status outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= IDLE;
      idx_r        <= {CH_W{1'b0}};
      pending_r    <= 1'b0;
      enable_r     <= 1'b0;
      step_duty_r  <= {W{1'b0}};
      step_phase_r <= {W{1'b0}};
      dutys_r      <= {(W*TRANS_NUM){1'b0}};
      phases_r     <= {(W*TRANS_NUM){1'b0}};
      busy_r       <= 1'b0;
      out_valid_r  <= 1'b0;
`ifdef SILENT_CONVERGED_EN
      conv_acc_r   <= 1'b0;
      converged_r  <= 1'b0;
`endif
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (UPDATE) begin
            state_r      <= SWEEP;
            busy_r       <= 1'b1;
            idx_r        <= {CH_W{1'b0}};
            enable_r     <= ENABLE;
            step_duty_r  <= STEP_DUTY;
            step_phase_r <= STEP_PHASE;
`ifdef SILENT_CONVERGED_EN
            conv_acc_r   <= 1'b1;
`endif
          end else begin
            busy_r <= 1'b0;
          end
        end
        SWEEP: begin
          dutys_r[idx_r*W +: W]  <= new_duty_s;
          phases_r[idx_r*W +: W] <= new_phase_s;
          if (UPDATE) begin
            pending_r <= 1'b1;
          end
`ifdef SILENT_CONVERGED_EN
          conv_acc_r <= conv_acc_r & ok_s;
`endif
          if (idx_r == LAST_IDX) begin
            state_r     <= DONE;
            idx_r       <= {CH_W{1'b0}};
            out_valid_r <= 1'b1;
`ifdef SILENT_CONVERGED_EN
            converged_r <= conv_acc_r & ok_s;
`endif
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        DONE: begin
          // A strobe seen during the sweep or right now chains a new sweep with no idle gap.
          if (pending_r || UPDATE) begin
            state_r      <= SWEEP;
            pending_r    <= 1'b0;
            idx_r        <= {CH_W{1'b0}};
            enable_r     <= ENABLE;
            step_duty_r  <= STEP_DUTY;
            step_phase_r <= STEP_PHASE;
`ifdef SILENT_CONVERGED_EN
            conv_acc_r   <= 1'b1;
`endif
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

  assign DUTYS     = dutys_r;
  assign PHASES    = phases_r;
  assign BUSY      = busy_r;
  assign OUT_VALID = out_valid_r;

endmodule

// File: tb/tb_silent_stepper_mc.sv
// Bench for silent_stepper_mc (W=8, 4 channels): integer reference model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_silent_stepper_mc;
  localparam int N = 4;
  localparam int W = 8;
  localparam int M = 1 << W;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b1;
  logic           update = 1'b0;
  logic [W-1:0]   step_duty = '0;
  logic [W-1:0]   step_phase = '0;
  logic [W*N-1:0] duty = '0;
  logic [W*N-1:0] phase = '0;
  logic [W*N-1:0] dutys;
  logic [W*N-1:0] phases;
  logic           busy;
  logic           out_valid;
`ifdef SILENT_CONVERGED_EN
  logic           converged;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  int m_duty[N];
  int m_phase[N];
  int m_pos = -1;
  bit m_pend = 1'b0;
  bit m_en = 1'b0;
  int m_sd = 0;
  int m_sp = 0;
  bit m_acc = 1'b0;
  bit m_conv = 1'b0;

  always #5 clk = ~clk;

  silent_stepper_mc #(.TRANS_NUM(N), .W(W)) dut (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .UPDATE(update),
    .STEP_DUTY(step_duty), .STEP_PHASE(step_phase), .DUTY(duty), .PHASE(phase),
    .DUTYS(dutys), .PHASES(phases), .BUSY(busy), .OUT_VALID(out_valid)
`ifdef SILENT_CONVERGED_EN
    , .CONVERGED(converged)
`endif
  );

  function automatic int duty_rule(input int c, input int t, input int s, input bit en);
    int d;
    d = t - c;
    if (!en || ((d < 0) ? -d : d) <= s) return t;
    return (d > 0) ? c + s : c - s;
  endfunction

  function automatic int phase_rule(input int c, input int t, input int s, input bit en);
    int d;
    d = ((t - c) % M + M) % M;
    if (d >= M / 2) d = d - M;
    if (!en || ((d < 0) ? -d : d) <= s) return t;
    if (d < 0 && d != -(M / 2)) return ((c - s) % M + M) % M;
    return (c + s) % M;
  endfunction

  task automatic chk(input string name, input int ch, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s ch=%0d actual=%0d expected=%0d at %0t", name, ch, act, exp, $time);
    end
  endtask

  // Reference model: pos -1 idle, 0..N-1 channel being processed, N = done cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_duty[k] = 0;
        m_phase[k] = 0;
      end
      m_pos = -1; m_pend = 1'b0; m_acc = 1'b0; m_conv = 1'b0;
    end else if ((m_pos < 0) || (m_pos == N && (m_pend || update))) begin
      if (m_pos < 0 && !update) begin
        m_pos = -1;
      end else begin
        m_sd = int'(step_duty); m_sp = int'(step_phase); m_en = enable;
        m_pos = 0; m_pend = 1'b0; m_acc = 1'b1;
      end
    end else if (m_pos < N) begin
      m_duty[m_pos]  = duty_rule(m_duty[m_pos], int'(duty[m_pos*W +: W]), m_sd, m_en);
      m_phase[m_pos] = phase_rule(m_phase[m_pos], int'(phase[m_pos*W +: W]), m_sp, m_en);
      m_acc = m_acc && (m_duty[m_pos] == int'(duty[m_pos*W +: W]))
                    && (m_phase[m_pos] == int'(phase[m_pos*W +: W]));
      if (m_pos == N - 1) m_conv = m_acc;
      if (update) m_pend = 1'b1;
      m_pos = m_pos + 1;
    end else begin
      m_pos = -1;
    end
  end

  task automatic sweep(output int lat);
    lat = -1;
    @(negedge clk);
    update = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      update = 1'b0;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout actual=no OUT_VALID expected=OUT_VALID within 40 cycles");
    end
  endtask

  initial begin
    int lat;
    int ov_cnt;
    int first_ov;
    int second_ov;
    fork
      forever begin
        @(negedge clk);
        if (cmp_on && rst_n) begin
          chk("busy", -1, int'(busy), (m_pos >= 0) ? 1 : 0);
          chk("out_valid", -1, int'(out_valid), (m_pos == N) ? 1 : 0);
          for (int k = 0; k < N; k++) begin
            chk("dutys", k, int'(dutys[k*W +: W]), m_duty[k]);
            chk("phases", k, int'(phases[k*W +: W]), m_phase[k]);
          end
`ifdef SILENT_CONVERGED_EN
          chk("converged", -1, int'(converged), int'(m_conv));
`endif
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_busy", -1, int'(busy), 0);
    chk("rst_out_valid", -1, int'(out_valid), 0);
    chk("rst_dutys", -1, int'(dutys), 0);
    chk("rst_phases", -1, int'(phases), 0);
    rst_n = 1'b1;
    cmp_on = 1'b1;

    // Duty ramp 0 -> 100 in steps of 16.
    enable = 1'b1; step_duty = 8'd16; step_phase = 8'd16;
    duty[7:0] = 8'd100;
    sweep(lat);
    chk("ov_latency", -1, lat, 5);
    chk("duty0_sweep1", 0, int'(dutys[7:0]), 16);
    sweep(lat);
    chk("duty0_sweep2", 0, int'(dutys[7:0]), 32);
    repeat (4) sweep(lat);
    chk("duty0_sweep6", 0, int'(dutys[7:0]), 96);
    sweep(lat);
    chk("duty0_sweep7", 0, int'(dutys[7:0]), 100);

    // Phase wrap in both directions on channel 1.
    enable = 1'b0; phase[15:8] = 8'd250;
    sweep(lat);
    chk("ph1_copy", 1, int'(phases[15:8]), 250);
    enable = 1'b1; step_phase = 8'd8; phase[15:8] = 8'd10;
    sweep(lat);
    chk("ph1_fwd1", 1, int'(phases[15:8]), 2);
    sweep(lat);
    chk("ph1_fwd2", 1, int'(phases[15:8]), 10);
    phase[15:8] = 8'd250;
    sweep(lat);
    chk("ph1_back1", 1, int'(phases[15:8]), 2);
    sweep(lat);
    chk("ph1_back2", 1, int'(phases[15:8]), 250);

    // Half-turn tie on channel 2.
    step_phase = 8'd200; phase[23:16] = 8'd128;
    sweep(lat);
    chk("ph2_half_big", 2, int'(phases[23:16]), 128);
    enable = 1'b0; phase[23:16] = 8'd0;
    sweep(lat);
    enable = 1'b1; step_phase = 8'd64; phase[23:16] = 8'd128;
    sweep(lat);
    chk("ph2_half_fwd", 2, int'(phases[23:16]), 64);

    // Step 0 holds outputs.
    step_duty = 8'd0; step_phase = 8'd0; duty[31:24] = 8'd77; phase[31:24] = 8'd33;
    sweep(lat);
    chk("step0_duty3", 3, int'(dutys[31:24]), 0);
    chk("step0_phase3", 3, int'(phases[31:24]), 0);

    // Bypass copies random targets.
    enable = 1'b0;
    for (int k = 0; k < N; k++) begin
      duty[k*W +: W]  = W'($urandom_range(0, 255));
      phase[k*W +: W] = W'($urandom_range(0, 255));
    end
    sweep(lat);
    chk("bypass_latency", -1, lat, 5);
    for (int k = 0; k < N; k++) begin
      chk("bypass_duty", k, int'(dutys[k*W +: W]), int'(duty[k*W +: W]));
      chk("bypass_phase", k, int'(phases[k*W +: W]), int'(phase[k*W +: W]));
    end

    // Extra strobes while busy collapse into one chained sweep.
    enable = 1'b1; step_duty = 8'd4; step_phase = 8'd4;
    @(negedge clk);
    update = 1'b1;
    repeat (4) @(negedge clk);
    update = 1'b0;
    ov_cnt = 0; first_ov = -1; second_ov = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ov_cnt++;
        if (first_ov < 0) first_ov = i;
        else second_ov = i;
      end
    end
    chk("pending_ov_count", -1, ov_cnt, 2);
    chk("pending_ov_gap", -1, second_ov - first_ov, N + 1);

    // Asynchronous reset while channel 2 is being processed.
    duty = '0; phase = '0; duty[7:0] = 8'd100; step_duty = 8'd16;
    @(negedge clk);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", -1, int'(busy), 0);
    chk("midrst_out_valid", -1, int'(out_valid), 0);
    chk("midrst_dutys", -1, int'(dutys), 0);
    chk("midrst_phases", -1, int'(phases), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    sweep(lat);
    chk("postrst_latency", -1, lat, 5);
    chk("postrst_duty0", 0, int'(dutys[7:0]), 16);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
